// File: rtl/vga_key_ctrl_pkg.sv
// rtl/vga_key_ctrl_pkg.sv - shared FSM encoding and VGA active-area constants
//
// Purpose : common types and constants for the VGA key control slice.
//           The VGA timing block also pulls the active-area defaults from here.
// Contents: key_state_t (IDLE/PEND/COMMIT), VGA_H_ACT/VGA_V_ACT defaults,
//           mode_next() wrap helper.
package vga_key_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_COMMIT = 2'd2
  } key_state_t;

  localparam int VGA_H_ACT = 640;
  localparam int VGA_V_ACT = 480;

  // Next display mode with wrap from mode_num-1 back to 0 (mode_num <= 4).
  function automatic logic [1:0] mode_next(input logic [1:0] m, input int mode_num);
    return (m == 2'(mode_num - 1)) ? 2'd0 : m + 2'd1;
  endfunction

endpackage

// File: rtl/vga_box_step.sv
// rtl/vga_box_step.sv - next box position with per-axis wrap
//
// Purpose : combinational step of the box top-left corner by STEP pixels.
//           X advances first; when X would push the box past the right edge
//           it wraps to 0 and Y advances, with Y wrapping the same way.
// Ports   : i_x, i_y  current position (10 bit)
//           o_x, o_y  position after one move (10 bit)
module vga_box_step
  import vga_key_ctrl_pkg::*;
#(
  parameter int H_ACT    = VGA_H_ACT,
  parameter int V_ACT    = VGA_V_ACT,
  parameter int BOX_SIZE = 64,
  parameter int STEP     = 16
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic [9:0] o_x,
  output logic [9:0] o_y
);

  localparam logic [10:0] X_MAX  = 11'(H_ACT - BOX_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACT - BOX_SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);

  // 11-bit sums so the overflow compare cannot itself overflow.
  logic [10:0] w_x_sum;
  logic [10:0] w_y_sum;

  assign w_x_sum = {1'b0, i_x} + STEP11;
  assign w_y_sum = {1'b0, i_y} + STEP11;

  always_comb begin
    o_x = w_x_sum[9:0];
    o_y = i_y;
    if (w_x_sum > X_MAX) begin
      o_x = '0;
      o_y = (w_y_sum > Y_MAX) ? 10'd0 : w_y_sum[9:0];
    end
  end

endmodule

// File: rtl/vga_key_ctrl.sv
// rtl/vga_key_ctrl.sv - key pulses to frame-synchronous VGA display control
//
// Purpose : key presses update shadow mode/box registers at once; the shadow
//           is copied to the outputs only on a frame_start seen while a change
//           is pending, so the pattern generator never sees a mid-frame change.
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           i_key_down     press pulses: bit0 next mode, bit1 move box
//           i_frame_start  one-cycle pulse at start of vertical blanking
//           o_mode         committed display mode
//           o_box_x/y      committed box top-left corner
//           o_upd          one-cycle pulse the cycle after a commit
module vga_key_ctrl
  import vga_key_ctrl_pkg::*;
#(
  parameter int KEY_W    = 2,
  parameter int MODE_NUM = 4,
  parameter int H_ACT    = VGA_H_ACT,
  parameter int V_ACT    = VGA_V_ACT,
  parameter int BOX_SIZE = 64,
  parameter int STEP     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] i_key_down,
  input  logic             i_frame_start,
  output logic [1:0]       o_mode,
  output logic [9:0]       o_box_x,
  output logic [9:0]       o_box_y,
  output logic             o_upd
);

  key_state_t r_state;
  key_state_t w_next_state;

  logic       w_key_mode;
  logic       w_key_move;
  logic       w_any_key;
  logic       w_unused_keys;

  logic [1:0] r_mode_s;
  logic [9:0] r_x_s;
  logic [9:0] r_y_s;
  logic [9:0] w_x_step;
  logic [9:0] w_y_step;

  logic       w_commit_load;
  logic       w_upd_next;
  logic       r_late_key;

  logic [1:0] r_mode;
  logic [9:0] r_box_x;
  logic [9:0] r_box_y;
  logic       r_upd;

  // Bits above 1 carry no function here.
  assign w_unused_keys = ^i_key_down;
  assign w_key_mode    = i_key_down[0];
  assign w_key_move    = i_key_down[1];
  assign w_any_key     = w_key_mode | w_key_move;

  vga_box_step #(
    .H_ACT    (H_ACT),
    .V_ACT    (V_ACT),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP)
  ) u_box_step (
    .i_x (r_x_s),
    .i_y (r_y_s),
    .o_x (w_x_step),
    .o_y (w_y_step)
  );

  // Shadow registers follow every key immediately; both bits may act together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_s <= 2'd0;
      r_x_s    <= 10'd0;
      r_y_s    <= 10'd0;
    end else begin
      if (w_key_mode) begin
        r_mode_s <= mode_next(r_mode_s, MODE_NUM);
      end
      if (w_key_move) begin
        r_x_s <= w_x_step;
        r_y_s <= w_y_step;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_key) w_next_state = ST_PEND;
      ST_PEND:   if (i_frame_start) w_next_state = ST_COMMIT;
      // A key that coincided with the committing frame_start, or one arriving
      // now, leaves shadow ahead of the outputs.
      ST_COMMIT: w_next_state = (w_any_key || r_late_key) ? ST_PEND : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs. The output copy is taken on the edge that enters COMMIT so
  // the committed value is the shadow from before any key in that same cycle
  // and is visible one cycle after frame_start; upd follows during the cycle
  // after COMMIT.
  always_comb begin
    w_commit_load = (r_state == ST_PEND) && i_frame_start;
    w_upd_next    = (r_state == ST_COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= 2'd0;
      r_box_x    <= 10'd0;
      r_box_y    <= 10'd0;
      r_upd      <= 1'b0;
      r_late_key <= 1'b0;
    end else begin
      r_upd      <= w_upd_next;
      r_late_key <= w_commit_load && w_any_key;
      if (w_commit_load) begin
        r_mode  <= r_mode_s;
        r_box_x <= r_x_s;
        r_box_y <= r_y_s;
      end
    end
  end

  assign o_mode  = r_mode;
  assign o_box_x = r_box_x;
  assign o_box_y = r_box_y;
  assign o_upd   = r_upd;

endmodule

// File: tb/tb_vga_key_ctrl.sv
// tb/tb_vga_key_ctrl.sv - scoreboard bench for vga_key_ctrl
module tb_vga_key_ctrl;

  localparam int MODE_NUM = 4;
  localparam int H_ACT    = 640;
  localparam int V_ACT    = 480;
  localparam int BOX_SIZE = 64;
  localparam int STEP     = 16;
  // Number of reachable positions on each axis.
  localparam int NX = (H_ACT - BOX_SIZE) / STEP + 1;
  localparam int NY = (V_ACT - BOX_SIZE) / STEP + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_down;
  logic       frame_start;
  logic [1:0] mode;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       upd;

  always #5 clk = ~clk;

  vga_key_ctrl #(
    .KEY_W    (2),
    .MODE_NUM (MODE_NUM),
    .H_ACT    (H_ACT),
    .V_ACT    (V_ACT),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_key_down    (key_down),
    .i_frame_start (frame_start),
    .o_mode        (mode),
    .o_box_x       (box_x),
    .o_box_y       (box_y),
    .o_upd         (upd)
  );

  typedef struct {
    int mode;
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: counts of presses since reset, pending flag.
  int m_mode_presses = 0;
  int m_moves        = 0;
  bit m_pend         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_mode();
    return m_mode_presses % MODE_NUM;
  endfunction
  function automatic int exp_x();
    return (m_moves % NX) * STEP;
  endfunction
  function automatic int exp_y();
    return ((m_moves / NX) % NY) * STEP;
  endfunction

  // Drive one cycle of stimulus and advance the model.
  task automatic drive(input logic [1:0] k, input logic fs);
    exp_t e;
    @(posedge clk);
    #1;
    key_down    = k;
    frame_start = fs;
    if (fs && m_pend) begin
      e.mode = exp_mode();
      e.x    = exp_x();
      e.y    = exp_y();
      e.cyc  = cyc + 2;
      q.push_back(e);
      m_pend = 0;
    end
    if (k[0]) m_mode_presses++;
    if (k[1]) m_moves++;
    if (k != 2'b00) m_pend = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 1'b0);
  endtask

  // Monitor: every upd pops one expectation; outputs must already hold the
  // committed value in the cycle before upd.
  int p_mode, p_x, p_y;
  always @(negedge clk) begin
    if (rst_n) begin
      if (upd) begin
        if (q.size() == 0) begin
          chk("unexpected_upd", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("upd_cycle", cyc, e.cyc);
          chk("mode", int'(mode), e.mode);
          chk("box_x", int'(box_x), e.x);
          chk("box_y", int'(box_y), e.y);
          chk("mode_before_upd", p_mode, e.mode);
          chk("box_x_before_upd", p_x, e.x);
          chk("box_y_before_upd", p_y, e.y);
        end
      end
      p_mode = int'(mode);
      p_x    = int'(box_x);
      p_y    = int'(box_y);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_box_x"}, int'(box_x), 0);
    chk({tag, "_box_y"}, int'(box_y), 0);
    chk({tag, "_upd"}, int'(upd), 0);
  endtask

  int gap;
  int r;

  initial begin
    rst_n       = 1'b0;
    key_down    = 2'b00;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // frame_start with nothing pending
    drive(2'b00, 1'b1);
    idle(4);
    chk_zero("idle_fs");

    // mode: three presses then commit, then one more to wrap
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b0);
      idle(1);
    end
    drive(2'b00, 1'b1);
    idle(4);
    drive(2'b01, 1'b0);
    drive(2'b00, 1'b1);
    idle(4);

    // box: 36 moves, then 1 more, then run to the last position, then wrap
    for (int i = 0; i < 36; i++) drive(2'b10, 1'b0);
    drive(2'b00, 1'b1);
    idle(4);
    drive(2'b10, 1'b0);
    drive(2'b00, 1'b1);
    idle(4);
    for (int i = 0; i < NX * NY - 1 - NX; i++) drive(2'b10, 1'b0);
    drive(2'b00, 1'b1);
    idle(4);
    drive(2'b10, 1'b0);
    drive(2'b00, 1'b1);
    idle(4);

    // both keys in the frame_start cycle while pending
    drive(2'b01, 1'b0);
    drive(2'b11, 1'b1);
    idle(4);
    drive(2'b00, 1'b1);
    idle(4);

    // reset between key and frame_start
    drive(2'b11, 1'b0);
    idle(1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_mode_presses = 0;
    m_moves        = 0;
    m_pend         = 0;
    chk("queue_before_reset", q.size(), 0);
    #1;
    chk_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    drive(2'b00, 1'b1);
    idle(4);
    chk_zero("after_reset_fs");
    // shadow was cleared: one press of each gives mode 1, x=STEP
    drive(2'b11, 1'b0);
    drive(2'b00, 1'b1);
    idle(4);

    // randomized keys and frame pulses
    gap = 5;
    for (int i = 0; i < 600; i++) begin
      logic [1:0] k;
      logic       fs;
      r  = $urandom_range(0, 9);
      k  = (r < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      fs = 1'b0;
      if (gap == 0) begin
        fs  = 1'b1;
        gap = $urandom_range(3, 15);
      end else begin
        gap--;
      end
      drive(k, fs);
    end

    idle(6);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
